// File: rtl/cam_ctrl_pkg.sv
// Shared types and helpers for the CAM access controller.
// Covers the FSM state encoding, the IDLE grant decision and a popcount helper.
package cam_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WRITE,
    SRCH_ISSUE,
    SRCH_WAIT,
    SRCH_RESP
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CLR,
    GNT_WR,
    GNT_SRCH
  } grant_e;

  // Bitmaps up to 32 entries (ADDR_WIDTH <= 5) are supported.
  function automatic int popcount(input logic [31:0] bits);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += int'(bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/cam_free_slot_finder.sv
// Lowest-zero priority encoder over the valid bitmap.
// full is high when every entry is in use; free_slot is 0 in that case.
module cam_free_slot_finder #(
  parameter int ADDR_WIDTH = 2
) (
  input  logic [(1<<ADDR_WIDTH)-1:0] valid,
  output logic [ADDR_WIDTH-1:0]      free_slot,
  output logic                       full
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Scan downwards so the last assignment wins for the lowest free index.
  always_comb begin
    free_slot = '0;
    full      = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_slot = ADDR_WIDTH'(i);
        full      = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cam_access_ctrl.sv
// Arbitrates enrol/search/clear requests onto a shared password CAM, owns slot
// allocation via a valid bitmap and times out searches the CAM never finishes.
module cam_access_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 4,
  parameter int ADDR_WIDTH   = 2,
  parameter int SRCH_TIMEOUT = 8   // must be at least 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  clr_ack,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic                  wr_full_err,
  output logic [ADDR_WIDTH-1:0] wr_slot,
  input  logic                  srch_req,
  input  logic [DATA_WIDTH-1:0] srch_data,
  output logic                  srch_done,
  output logic                  srch_hit,
  output logic [ADDR_WIDTH-1:0] srch_slot,
  output logic                  srch_timeout,
  output logic                  cam_we,
  output logic [DATA_WIDTH-1:0] cam_din,
  output logic [ADDR_WIDTH-1:0] cam_wr_addr,
  output logic [DATA_WIDTH-1:0] cam_cmp_din,
  input  logic                  cam_match,
  input  logic                  cam_busy,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr,
  output logic                  ctrl_busy,
  output logic [ADDR_WIDTH:0]   entry_count,
  output state_e                dbg_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = $clog2(SRCH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRCH_TIMEOUT - 1);

  state_e                state, state_next;
  grant_e                grant;
  logic [DEPTH-1:0]      valid;
  logic                  rr;        // 0: write wins a tie, 1: search wins
  logic [CNT_W-1:0]      wait_cnt;
  logic                  to_q;
  logic                  match_q;
  logic [ADDR_WIDTH-1:0] match_addr_q;
  logic [DATA_WIDTH-1:0] cmp_din_q;
  logic [ADDR_WIDTH-1:0] free_slot;
  logic                  full;
  logic                  do_write;

  cam_free_slot_finder #(.ADDR_WIDTH(ADDR_WIDTH)) u_finder (
    .valid     (valid),
    .free_slot (free_slot),
    .full      (full)
  );

  always_comb begin
    grant = GNT_NONE;
    if (clr_req)                grant = GNT_CLR;
    else if (wr_req && srch_req) grant = rr ? GNT_SRCH : GNT_WR;
    else if (wr_req)             grant = GNT_WR;
    else if (srch_req)           grant = GNT_SRCH;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        case (grant)
          GNT_CLR:  state_next = CLEAR;
          GNT_WR:   state_next = WRITE;
          GNT_SRCH: state_next = SRCH_ISSUE;
          default:  state_next = IDLE;
        endcase
      end
      CLEAR:      state_next = IDLE;
      WRITE:      state_next = IDLE;
      SRCH_ISSUE: state_next = SRCH_WAIT;
      SRCH_WAIT: begin
        if (!cam_busy || wait_cnt == CNT_LAST) state_next = SRCH_RESP;
      end
      SRCH_RESP:  state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  assign do_write = (state == WRITE) && !full;

  always_comb begin
    clr_ack      = (state == CLEAR);
    wr_ack       = (state == WRITE);
    wr_full_err  = (state == WRITE) && full;
    wr_slot      = do_write ? free_slot : '0;
    cam_we       = do_write;
    cam_din      = do_write ? wr_data : '0;
    cam_wr_addr  = do_write ? free_slot : '0;
    srch_done    = (state == SRCH_RESP);
    // A match on an entry cleared since it was written is stale and ignored.
    srch_hit     = srch_done && match_q && valid[match_addr_q] && !to_q;
    srch_slot    = srch_hit ? match_addr_q : '0;
    srch_timeout = srch_done && to_q;
    ctrl_busy    = (state != IDLE);
  end

  assign cam_cmp_din = cmp_din_q;
  assign entry_count = (ADDR_WIDTH + 1)'(popcount(32'(valid)));
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      valid        <= '0;
      rr           <= 1'b0;
      wait_cnt     <= '0;
      to_q         <= 1'b0;
      match_q      <= 1'b0;
      match_addr_q <= '0;
      cmp_din_q    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && (grant == GNT_WR || grant == GNT_SRCH)) rr <= ~rr;
      if (state == CLEAR) valid <= '0;
      if (do_write) valid[free_slot] <= 1'b1;
      case (state)
        SRCH_ISSUE: begin
          cmp_din_q    <= srch_data;
          wait_cnt     <= '0;
          to_q         <= 1'b0;
          match_q      <= 1'b0;
          match_addr_q <= '0;
        end
        SRCH_WAIT: begin
          if (!cam_busy) begin
            match_q      <= cam_match;
            match_addr_q <= cam_match_addr;
          end else if (wait_cnt == CNT_LAST) begin
            to_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_access_ctrl.sv
// Bench for cam_access_ctrl: table of enrol/search/clear vectors, arbitration
// and mid-search reset sequences, with a response scoreboard.
module tb_cam_access_ctrl;
  import cam_ctrl_pkg::*;

  localparam int DW    = 4;
  localparam int AW    = 2;
  localparam int TO    = 8;
  localparam int REC_W = 13;
  localparam int LIMIT = 40;
  localparam int NV    = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_req = 1'b0, wr_req = 1'b0, srch_req = 1'b0;
  logic [DW-1:0] wr_data = '0, srch_data = '0;
  logic cam_match = 1'b0, cam_busy = 1'b0;
  logic [AW-1:0] cam_match_addr = '0;
  logic clr_ack, wr_ack, wr_full_err, srch_done, srch_hit, srch_timeout;
  logic [AW-1:0] wr_slot, srch_slot, cam_wr_addr;
  logic cam_we, ctrl_busy;
  logic [DW-1:0] cam_din, cam_cmp_din;
  logic [AW:0] entry_count;
  state_e dbg_state;

  always #5 clk = ~clk;

  cam_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRCH_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .clr_req(clr_req), .clr_ack(clr_ack),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .wr_full_err(wr_full_err), .wr_slot(wr_slot),
    .srch_req(srch_req), .srch_data(srch_data), .srch_done(srch_done),
    .srch_hit(srch_hit), .srch_slot(srch_slot), .srch_timeout(srch_timeout),
    .cam_we(cam_we), .cam_din(cam_din), .cam_wr_addr(cam_wr_addr),
    .cam_cmp_din(cam_cmp_din), .cam_match(cam_match), .cam_busy(cam_busy),
    .cam_match_addr(cam_match_addr), .ctrl_busy(ctrl_busy),
    .entry_count(entry_count), .dbg_state(dbg_state)
  );

  typedef enum logic [1:0] {OP_NONE = 2'd0, OP_CLR = 2'd1, OP_WR = 2'd2, OP_SRCH = 2'd3} op_e;

  typedef struct {
    op_e          op;
    logic [DW-1:0] data;
    int           busy;
    logic         match;
    logic [AW-1:0] maddr;
    logic         flag;
    logic [AW-1:0] slot;
    logic         to;
    int           lat;
    int           count;
  } vec_t;

  vec_t vecs[NV];
  int n_vec = 0;
  int n_err = 0;
  int stray_we = 0;
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] mon_act, mon_exp;
  logic [24:0] all_out;

  assign all_out = {clr_ack, wr_ack, wr_full_err, wr_slot, srch_done, srch_hit, srch_slot,
                    srch_timeout, cam_we, cam_din, cam_wr_addr, cam_cmp_din, ctrl_busy, entry_count};

  function automatic logic [REC_W-1:0] mk_rec(input logic [1:0] kind, input logic flag,
      input logic [AW-1:0] slot, input logic to, input logic we, input logic [AW-1:0] waddr,
      input logic [DW-1:0] data);
    return {kind, flag, slot, to, we, waddr, data};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: every ack/done pulse is matched against the expected queue.
  always @(negedge clk) begin
    if (cam_we && !wr_ack) stray_we++;
    if (rst_n && (clr_ack || wr_ack || srch_done)) begin
      mon_act = mk_rec(clr_ack ? 2'd1 : (wr_ack ? 2'd2 : 2'd3),
                       wr_ack ? wr_full_err : srch_hit,
                       wr_ack ? wr_slot : srch_slot,
                       srch_timeout, cam_we, cam_wr_addr, cam_din);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_resp: got %0h expected none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        check("resp", 32'(mon_act), 32'(mon_exp));
      end
    end
  end

  task automatic run_vec(input vec_t v, input string name);
    int k;
    bit done;
    case (v.op)
      OP_CLR:  exp_q.push_back(mk_rec(2'd1, 1'b0, '0, 1'b0, 1'b0, '0, '0));
      OP_WR:   exp_q.push_back(mk_rec(2'd2, v.flag, v.slot, 1'b0, !v.flag,
                                      v.flag ? '0 : v.slot, v.flag ? '0 : v.data));
      default: exp_q.push_back(mk_rec(2'd3, v.flag, v.slot, v.to, 1'b0, '0, '0));
    endcase
    clr_req = (v.op == OP_CLR);
    wr_req = (v.op == OP_WR);
    srch_req = (v.op == OP_SRCH);
    wr_data = v.data;
    srch_data = v.data;
    cam_match = v.match;
    cam_match_addr = v.maddr;
    cam_busy = (v.op == OP_SRCH);
    k = 0;
    done = 0;
    while (!done && k < LIMIT) begin
      @(negedge clk);
      k++;
      case (v.op)
        OP_CLR:  done = clr_ack;
        OP_WR:   done = wr_ack;
        default: done = srch_done;
      endcase
      if (v.op == OP_SRCH) cam_busy = (k < v.busy + 2);
    end
    clr_req = 1'b0;
    wr_req = 1'b0;
    srch_req = 1'b0;
    cam_busy = 1'b0;
    check({name, "_lat"}, 32'(k), 32'(v.lat));
    @(negedge clk);
    check({name, "_count"}, 32'(entry_count), 32'(v.count));
    if (v.op == OP_SRCH) check({name, "_cmp_din"}, 32'(cam_cmp_din), 32'(v.data));
  endtask

  // Both requesters raise together; write must be acked first, search right after.
  task automatic arb_round(input logic [DW-1:0] d, input logic [AW-1:0] slot, input string name);
    int k, wk, sk;
    exp_q.push_back(mk_rec(2'd2, 1'b0, slot, 1'b0, 1'b1, slot, d));
    exp_q.push_back(mk_rec(2'd3, 1'b1, slot, 1'b0, 1'b0, '0, '0));
    wr_req = 1'b1;
    srch_req = 1'b1;
    wr_data = d;
    srch_data = d;
    cam_match = 1'b1;
    cam_match_addr = slot;
    cam_busy = 1'b0;
    k = 0;
    wk = -1;
    sk = -1;
    while ((wk < 0 || sk < 0) && k < LIMIT) begin
      @(negedge clk);
      k++;
      if (wr_ack && wk < 0) begin wk = k; wr_req = 1'b0; end
      if (srch_done && sk < 0) begin sk = k; srch_req = 1'b0; end
    end
    wr_req = 1'b0;
    srch_req = 1'b0;
    check({name, "_wr_first"}, 32'(wk), 32'd1);
    check({name, "_srch_second"}, 32'(sk), 32'd5);
    @(negedge clk);
  endtask

  initial begin
    vec_t extra;
    vecs[0]  = '{OP_WR,   4'hA, 0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1, 1};
    vecs[1]  = '{OP_WR,   4'h3, 0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b0, 1, 2};
    vecs[2]  = '{OP_WR,   4'h7, 0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 1, 3};
    vecs[3]  = '{OP_WR,   4'hC, 0, 1'b0, 2'd0, 1'b0, 2'd3, 1'b0, 1, 4};
    vecs[4]  = '{OP_WR,   4'h5, 0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1, 4};
    vecs[5]  = '{OP_SRCH, 4'h7, 2, 1'b1, 2'd2, 1'b1, 2'd2, 1'b0, 5, 4};
    vecs[6]  = '{OP_SRCH, 4'h9, 0, 1'b0, 2'd3, 1'b0, 2'd0, 1'b0, 3, 4};
    vecs[7]  = '{OP_SRCH, 4'hA, 1, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 4, 4};
    vecs[8]  = '{OP_CLR,  4'h0, 0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1, 0};
    vecs[9]  = '{OP_SRCH, 4'h7, 0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 3, 0};
    vecs[10] = '{OP_WR,   4'h6, 0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1, 1};
    vecs[11] = '{OP_SRCH, 4'h6, 8, 1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 10, 1};
    vecs[12] = '{OP_WR,   4'hE, 0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b0, 1, 2};
    vecs[13] = '{OP_SRCH, 4'hE, 3, 1'b1, 2'd1, 1'b1, 2'd1, 1'b0, 6, 2};

    #12;
    check("rst_outputs", 32'(all_out), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    arb_round(4'h1, 2'd0, "arb0");
    arb_round(4'h2, 2'd1, "arb1");

    srch_req = 1'b1;
    srch_data = 4'hB;
    cam_busy = 1'b1;
    cam_match = 1'b1;
    cam_match_addr = 2'd0;
    repeat (3) @(negedge clk);
    check("abort_in_wait", 32'(dbg_state), 32'(SRCH_WAIT));
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 32'(all_out), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    srch_req = 1'b0;
    cam_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_idle", 32'(dbg_state), 32'(IDLE));
    extra = '{OP_WR, 4'h9, 0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1, 1};
    run_vec(extra, "post_abort_wr");

    repeat (2) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("stray_we", 32'(stray_we), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cam_access_ctrl.md
Name: cam_access_ctrl

Overview:
- Sequences and shares the password CAM between two requesters: an enrol (write) client and a search (compare) client.
- Owns slot allocation: keeps a valid bitmap, writes each enrol into the lowest free entry, masks matches on stale entries.
- Serialises compare operations against the CAM Busy/Match handshake, with a timeout.
- Sits between the host-side command logic and the CAM datapath.

Parameters:
- DATA_WIDTH, 4, CAM word width.
- ADDR_WIDTH, 2, CAM address width; depth = 2**ADDR_WIDTH.
- SRCH_TIMEOUT, 8, max cycles spent waiting for cam_busy low (minimum 2).

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Rest  in  1  asynchronous active-low reset.
- clr_req  in  1  level request: invalidate all entries.
- clr_ack  out  1  one-cycle pulse: clear done.
- wr_req  in  1  level request: enrol wr_data.
- wr_data  in  DATA_WIDTH  word to enrol.
- wr_ack  out  1  one-cycle pulse: enrol complete.
- wr_full_err  out  1  valid with wr_ack; 1 = table full, nothing written.
- wr_slot  out  ADDR_WIDTH  valid with wr_ack; slot written.
- srch_req  in  1  level request: search srch_data.
- srch_data  in  DATA_WIDTH  word to compare.
- srch_done  out  1  one-cycle pulse: search result valid.
- srch_hit  out  1  valid with srch_done.
- srch_slot  out  ADDR_WIDTH  valid with srch_done; matching slot; 0 on miss.
- srch_timeout  out  1  valid with srch_done; CAM never went idle.
- cam_we  out  1  CAM Writ_Enable.
- cam_din  out  DATA_WIDTH  CAM Data_IN.
- cam_wr_addr  out  ADDR_WIDTH  CAM WR_Addr.
- cam_cmp_din  out  DATA_WIDTH  CAM CMP_Din; registered and held.
- cam_match  in  1  CAM Match.
- cam_busy  in  1  CAM Busy.
- cam_match_addr  in  ADDR_WIDTH  CAM Match_Addr.
- ctrl_busy  out  1  high in any state other than IDLE.
- entry_count  out  ADDR_WIDTH+1  popcount of the valid bitmap.

Behaviour:
- Reset (Rest=0, asynchronous): state IDLE, valid bitmap cleared, rr pointer cleared (write favoured next). All outputs 0, including cam_cmp_din and entry_count.
- Reset asserted mid-operation aborts it; no ack or done is ever emitted for the aborted request.
- Requesters hold req high until their ack/done pulse and drop req in the following cycle.
- FSM states: IDLE, CLEAR, WRITE, SRCH_ISSUE, SRCH_WAIT, SRCH_RESP.
- IDLE priority: clr_req wins over everything. Otherwise, if wr_req and srch_req are both high, grant round-robin using the rr pointer (toggles on every wr/srch grant). Otherwise grant whichever request is present.
- CLEAR (1 cycle): bitmap <= 0, clr_ack=1, then IDLE. Clear does not touch CAM contents.
- WRITE (1 cycle), table not full:
  - cam_we=1, cam_wr_addr = lowest free slot, cam_din = wr_data;
  - set that valid bit; wr_ack=1, wr_slot = that slot, wr_full_err=0.
- WRITE (1 cycle), table full: cam_we=0, wr_ack=1, wr_full_err=1, wr_slot=0.
- Enrol latency is 2 cycles from a granted wr_req (IDLE grant, WRITE ack). Duplicates are not checked.
- SRCH_ISSUE (1 cycle): cam_cmp_din <= srch_data, timeout counter cleared. cam_cmp_din holds its value until the next search.
- SRCH_WAIT: each cycle, if cam_busy==0 go to SRCH_RESP and sample cam_match/cam_match_addr. Otherwise increment the counter; at SRCH_TIMEOUT go to SRCH_RESP with timeout set.
- SRCH_RESP (1 cycle): srch_done=1.
  - srch_hit = cam_match & valid[cam_match_addr] & ~timeout;
  - srch_slot = cam_match_addr if hit, else 0; srch_timeout = timeout flag.
- Minimum search latency: 4 cycles (IDLE, ISSUE, WAIT with busy low, RESP).
- cam_we is 1 only in WRITE; cam_din and cam_wr_addr are 0 outside WRITE.
- entry_count updates the cycle after a WRITE or CLEAR; maximum value is 2**ADDR_WIDTH.
- Requests raised while not in IDLE wait; nothing is dropped.

Decomposition:
- Package cam_ctrl_pkg:
  - state enum (state_e);
  - grant enum (GNT_NONE, GNT_CLR, GNT_WR, GNT_SRCH);
  - helper function popcount.
- Sub-module cam_free_slot_finder: combinational lowest-zero priority encoder over the bitmap; outputs free_slot and full.

Test Plan:
- Reset, then 4 enrols of 4'hA, 4'h3, 4'h7, 4'hC -> wr_slot 0,1,2,3, wr_full_err=0, entry_count 4; 5th enrol -> wr_full_err=1, cam_we never asserted.
- Search 4'h7 with CAM returning busy for 2 cycles then match, addr 2 -> srch_done 5 cycles after grant, hit=1, slot=2.
- clr_req, then search 4'h7 with CAM still matching addr 2 -> hit=0 (stale entry masked); entry_count 0; next enrol goes to slot 0.
- wr_req and srch_req raised in the same cycle, repeated twice -> grants alternate write, search, write, search.
- cam_busy held high with SRCH_TIMEOUT=8 -> srch_done with srch_timeout=1, hit=0, 10 cycles after grant.
- Rest pulsed low during SRCH_WAIT -> no srch_done, all outputs 0, entry_count 0, state IDLE.
